// File: rtl/cnu_pkg.sv
// cnu_pkg: shared constants, message types and min-search helpers for the degree-6 check node unit
// Contents: W/DEG constants, msg_t/mag_t/idx_t/min_t types, sat_abs() and merge() helpers.
package cnu_pkg;
    localparam int W   = 32;
    localparam int DEG = 6;

    typedef logic signed [W-1:0] msg_t;
    typedef logic [W-2:0]        mag_t;
    typedef logic [2:0]          idx_t;

    typedef struct packed {
        mag_t m1;
        mag_t m2;
        idx_t idx;
    } min_t;

    // The most negative message has no positive twin, so clamp it to the largest magnitude.
    function automatic mag_t sat_abs(msg_t v);
        msg_t n;
        n = -v;
        return !v[W-1] ? v[W-2:0] : n[W-1] ? '1 : n[W-2:0];
    endfunction

    // a covers lower input indices than b, so a wins ties and keeps the lowest index.
    function automatic min_t merge(min_t a, min_t b);
        min_t o;
        if (b.m1 < a.m1) begin
            o.m1  = b.m1;
            o.m2  = a.m1 < b.m2 ? a.m1 : b.m2;
            o.idx = b.idx;
        end else begin
            o.m1  = a.m1;
            o.m2  = a.m2 < b.m1 ? a.m2 : b.m1;
            o.idx = a.idx;
        end
        return o;
    endfunction
endpackage

// File: rtl/cnu_6_if.sv
// cnu_6_if: message bundle between variable nodes and the check node unit
// Signals: q1..q6 incoming messages (master drives), r1..r6 outgoing messages (slave drives).
interface cnu_6_if;
    import cnu_pkg::*;
    msg_t q1, q2, q3, q4, q5, q6;
    msg_t r1, r2, r3, r4, r5, r6;
    modport master (output q1, q2, q3, q4, q5, q6, input r1, r2, r3, r4, r5, r6);
    modport slave (input q1, q2, q3, q4, q5, q6, output r1, r2, r3, r4, r5, r6);
endinterface

// File: rtl/cnu_min2_finder.sv
// cnu_min2_finder: smallest and second-smallest of DEG magnitudes plus the index of the smallest
// Ports: mags (DEG magnitudes) in; min1, min2, idx out. Pairwise comparison tree; lowest index wins ties.
module cnu_min2_finder
    import cnu_pkg::*;
(
    input  mag_t mags [DEG],
    output mag_t min1,
    output mag_t min2,
    output idx_t idx
);
    min_t l [DEG];
    min_t p01, p23, p45, p03, t;

    // Each leaf is a single candidate whose second minimum is the largest possible magnitude.
    always_comb begin
        for (int i = 0; i < DEG; i++)
            l[i] = {mags[i], {(W-1){1'b1}}, idx_t'(i)};
    end

    assign p01 = merge(l[0], l[1]);
    assign p23 = merge(l[2], l[3]);
    assign p45 = merge(l[4], l[5]);
    assign p03 = merge(p01, p23);
    assign t   = merge(p03, p45);

    assign min1 = t.m1;
    assign min2 = t.m2;
    assign idx  = t.idx;
endmodule

// File: rtl/cnu_6.sv
// cnu_6: six-input min-sum check node unit with one registered output stage
// Ports: clk, rst_n (async active-low), bus (cnu_6_if.slave: q1..q6 in, r1..r6 registered out).
// Config: define CNU_OFFSET_EN for offset min-sum (magnitudes reduced by OFFSET, floored at 0).
module cnu_6
    import cnu_pkg::*;
#(
    parameter int OFFSET = 1
) (
    input logic   clk,
    input logic   rst_n,
    cnu_6_if.slave bus
);
`ifdef CNU_OFFSET_EN
    localparam mag_t OFS = mag_t'(OFFSET);
`else
    // Plain min-sum subtracts nothing.
    localparam mag_t OFS = mag_t'(OFFSET * 0);
`endif

    msg_t           q [DEG];
    mag_t           m [DEG];
    mag_t           sel [DEG];
    mag_t           om [DEG];
    msg_t           d [DEG];
    msg_t           r [DEG];
    logic [DEG-1:0] sg;
    logic           s;
    mag_t           min1, min2;
    idx_t           idx;

    assign q = '{bus.q1, bus.q2, bus.q3, bus.q4, bus.q5, bus.q6};

    always_comb begin
        for (int i = 0; i < DEG; i++) begin
            sg[i] = q[i][W-1];
            m[i]  = sat_abs(q[i]);
        end
    end

    assign s = ^sg;

    cnu_min2_finder u_min (
        .mags (m),
        .min1 (min1),
        .min2 (min2),
        .idx  (idx)
    );

    // The extrinsic sign drops each input's own sign from the overall parity;
    // negating a zero magnitude yields zero, so no negative zero can appear.
    always_comb begin
        for (int i = 0; i < DEG; i++) begin
            sel[i] = idx_t'(i) == idx ? min2 : min1;
            om[i]  = sel[i] > OFS ? sel[i] - OFS : '0;
            d[i]   = (s ^ sg[i]) ? -msg_t'({1'b0, om[i]}) : msg_t'({1'b0, om[i]});
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r <= '{default: '0};
        else        r <= d;

    assign bus.r1 = r[0];
    assign bus.r2 = r[1];
    assign bus.r3 = r[2];
    assign bus.r4 = r[3];
    assign bus.r5 = r[4];
    assign bus.r6 = r[5];
endmodule

// File: tb/tb_cnu_6.sv
// tb_cnu_6: directed self-checking bench for cnu_6 (plain or offset min-sum via CNU_OFFSET_EN)
module tb_cnu_6;
    import cnu_pkg::*;

`ifdef CNU_OFFSET_EN
    localparam longint OFS = 1;
`else
    localparam longint OFS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    cnu_6_if bus ();

    cnu_6 #(.OFFSET(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input msg_t got, input msg_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    // Converts a hand-computed plain min-sum output into the expected value for this build.
    function automatic msg_t e(input longint v);
        longint a;
        a = (v < 0 ? -v : v) - OFS;
        if (a < 0) a = 0;
        return msg_t'(v < 0 ? -a : a);
    endfunction

    task automatic set_q(input msg_t a, b, c, d, f, g);
        bus.q1 = a; bus.q2 = b; bus.q3 = c; bus.q4 = d; bus.q5 = f; bus.q6 = g;
    endtask

    task automatic chk_r(input string tag, input msg_t a, b, c, d, f, g);
        check({tag, ".r1"}, bus.r1, a);
        check({tag, ".r2"}, bus.r2, b);
        check({tag, ".r3"}, bus.r3, c);
        check({tag, ".r4"}, bus.r4, d);
        check({tag, ".r5"}, bus.r5, f);
        check({tag, ".r6"}, bus.r6, g);
    endtask

    task automatic step(input string tag, input msg_t a, b, c, d, f, g);
        @(posedge clk);
        #1;
        chk_r(tag, a, b, c, d, f, g);
    endtask

    initial begin
        set_q(-2, -4, 5, -6, 7, 8);
        repeat (2) @(posedge clk);
        #1;
        chk_r("reset", 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre_edge.r1", bus.r1, 0);

        // Consecutive sets, one per cycle, each visible right after its edge.
        step("mixed", e(4), e(2), e(-2), e(2), e(-2), e(-2));
        @(negedge clk) set_q(3, -3, 9, 9, 9, 9);
        step("tied", e(-3), e(3), e(-3), e(-3), e(-3), e(-3));
        @(negedge clk) set_q(0, -5, 6, 7, 8, 9);
        step("zero", e(-5), 0, 0, 0, 0, 0);
        @(negedge clk) set_q(32'sh80000000, -32'sh7FFFFFFF, -32'sh7FFFFFFF,
                             -32'sh7FFFFFFF, -32'sh7FFFFFFF, -32'sh7FFFFFFF);
        step("sat", e(-64'sh7FFFFFFF), e(-64'sh7FFFFFFF), e(-64'sh7FFFFFFF),
             e(-64'sh7FFFFFFF), e(-64'sh7FFFFFFF), e(-64'sh7FFFFFFF));
        @(negedge clk) set_q(1, 1, 1, 1, 1, 1);
        step("ones", e(1), e(1), e(1), e(1), e(1), e(1));
        @(negedge clk) set_q(-2, -4, 5, -6, 7, 8);
        step("b2b_a", e(4), e(2), e(-2), e(2), e(-2), e(-2));
        @(negedge clk) set_q(1, 1, 1, 1, 1, 1);
        step("b2b_b", e(1), e(1), e(1), e(1), e(1), e(1));
        @(negedge clk) set_q(10, 20, -30, 40, 50, -5);
        step("idx6", e(5), e(5), e(-5), e(5), e(5), e(-10));

        // Mid-operation reset clears outputs without a clock edge and holds them.
        @(negedge clk) set_q(3, -3, 9, 9, 9, 9);
        #2 rst_n = 1'b0;
        #1;
        chk_r("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_r("rst_hold", 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        step("after_rst", e(-3), e(3), e(-3), e(-3), e(-3), e(-3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cnu_6.md
# cnu_6

Six-input check node unit (CNU) for the LDPC min-sum decoder. Each cycle it takes six signed variable-to-check messages Q1..Q6 and returns six check-to-variable messages R1..R6. Each Ri is the min-sum extrinsic update computed from the other five inputs. It sits between the variable node units and the message memories in a degree-6 check row, with one registered stage.

## Interface
Parameters:
- W, 32: message width in bits, two's complement.
- OFFSET, 1: offset subtracted from the magnitude when CNU_OFFSET_EN is defined.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- Q1..Q6  input  W each  signed incoming messages.
- R1..R6  output  W each  signed outgoing messages, registered.

## Operation
- Sign of each input is its MSB, so 0 counts as positive.
- Sign of each output:
  - S = XOR of all six input signs.
  - sign(Ri) = S XOR sign(Qi), the product of the other five signs.
- Magnitude of each input:
  - |Qi| is the absolute value.
  - The most negative value (-2^(W-1)) saturates to 2^(W-1)-1.
- Minimum search:
  - min1 = smallest magnitude; idx = its position (lowest index wins ties).
  - min2 = second smallest magnitude; min2 equals min1 when the minimum is duplicated.
- Output magnitude: mag(Ri) = min2 if i == idx, otherwise min1.
- Output value: Ri = -mag when sign(Ri)=1, else +mag.
  - A zero magnitude always gives Ri = 0, never a negative zero.
- Fully combinational datapath into one output register bank; there is no handshake.

## Timing
- Inputs are sampled on the rising edge of clk.
- R1..R6 reflect those inputs immediately after the same edge (latency 1 cycle).
- Throughput is one new input set per cycle.
- rst_n low clears R1..R6 to 0 asynchronously.
  - Outputs hold 0 while rst_n is low.
  - The first update occurs on the first rising edge after rst_n deasserts.
- A reset asserted mid-operation discards the in-flight result; there is no other state.
- X or undriven inputs are not filtered; the bench drives all inputs before releasing reset.

## Configuration
- CNU_OFFSET_EN defined (offset min-sum):
  - mag(Ri) = max(selected_min - OFFSET, 0), applied before the sign.
  - The result is 0 when the magnitude is ≤ OFFSET.
- CNU_OFFSET_EN undefined (plain min-sum): mag(Ri) = selected_min exactly, and OFFSET is unused.

## Structure
- Package cnu_pkg holds:
  - W and DEG (= 6) constants;
  - typedefs msg_t (signed W) and mag_t (unsigned W-1);
  - the index type idx_t (3 bits).
- Sub-module cnu_min2_finder:
  - inputs: DEG magnitudes;
  - outputs: min1, min2, idx;
  - built as a comparison tree.
- The top level contains the sign/magnitude split, the XOR sign logic, output reconstruction, the optional offset stage and the register bank.

## Test plan
Without CNU_OFFSET_EN unless noted:
- Reset: hold rst_n=0 and drive arbitrary inputs -> R1..R6 = 0.
  - Release reset -> outputs update on the next edge.
- Mixed signs: Q = -2, -4, 5, -6, 7, 8 -> one cycle later R = 4, 2, -2, 2, -2, -2.
- Tied minimum: Q = 3, -3, 9, 9, 9, 9 -> R = -3, 3, -3, -3, -3, -3.
- Zero input: Q = 0, -5, 6, 7, 8, 9 -> R = -5, 0, 0, 0, 0, 0.
- Saturation: Q1 = 0x80000000, others = -0x7FFFFFFF.
  - Expected R = 0x80000001 on all six outputs; every Ri is negative because the other five signs multiply to -1.
- Offset (CNU_OFFSET_EN, OFFSET=1): Q = -2, -4, 5, -6, 7, 8 -> R = 3, 1, -1, 1, -1, -1.
  - Then Q = 1, 1, 1, 1, 1, 1 -> all R = 0.
- Back-to-back: apply the two input sets on consecutive cycles -> outputs change on consecutive edges with latency 1.
